vga_scan_ctrl: RTL and testbench

VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

---
 rtl/vga_scan_ctrl.sv | 108 ++++++++++
 tb/tb_vga_scan_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator: pixel-rate divider, line/frame counters and a
// registered sync/colour output stage that trails the scan position by one pixel.
module vga_scan_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [11:0] pix_color,
  output logic [9:0]  posX,
  output logic [8:0]  posY,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        active,
  output logic        pix_en,
  output logic        frame_start,
  output logic [7:0]  frame_cnt
);

  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       hcnt;
  logic [9:0]       vcnt;
  logic             h_wrap;
  logic             v_wrap;
  logic             vis;
  logic             raw_hs;
  logic             raw_vs;

  assign pix_en = (div == DIV_LAST);
  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);
  assign vis    = (hcnt < H_VIS) && (vcnt < V_VIS);
  assign raw_hs = !((hcnt >= HS_START) && (hcnt < HS_END));
  assign raw_vs = !((vcnt >= VS_START) && (vcnt < VS_END));

  assign posX = hcnt;
  assign posY = vcnt[8:0];

  // Scan position; the frame pulse lands in the clk where both counters read zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      div         <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      div         <= pix_en ? '0 : div + DIV_W'(1);
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_wrap) begin
          hcnt <= '0;
          if (v_wrap) begin
            vcnt        <= '0;
            frame_start <= 1'b1;
            frame_cnt   <= frame_cnt + 8'd1;
          end else begin
            vcnt <= vcnt + 10'd1;
          end
        end else begin
          hcnt <= hcnt + 10'd1;
        end
      end
    end
  end

  // Output stage captures the pixel being left, so it is one pixel behind posX/posY.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hs     <= 1'b1;
      vs     <= 1'b1;
      active <= 1'b0;
      r      <= '0;
      g      <= '0;
      b      <= '0;
    end else if (pix_en) begin
      hs        <= raw_hs;
      vs        <= raw_vs;
      active    <= vis;
      {r, g, b} <= vis ? pix_color : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a shrunken raster (14 x 8 pixels, 2 clk/pixel)
// so that a 256-frame wrap fits in a short run.
module tb_vga_scan_ctrl;

  localparam int CLK_DIV  = 2;
  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 3;
  localparam int H_BP     = 1;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 1;
  localparam int H_TOTAL  = 14;
  localparam int V_TOTAL  = 8;
  localparam int LINE_CLK  = 28;
  localparam int FRAME_CLK = 224;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [11:0] pix_color = 12'hFFF;
  logic [9:0]  posX;
  logic [8:0]  posY;
  logic        hs, vs, active, pix_en, frame_start;
  logic [3:0]  r, g, b;
  logic [7:0]  frame_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] exp_rgb [0:H_TOTAL-1];

  int s_hs_low, s_vs_low, s_act, s_fs, s_strobe, s_hold;
  int s_hs_x, s_vs_x, s_vs_y, s_fs_x, s_fs_y, s_fs_cnt;

  vga_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk), .clrn(clrn), .pix_color(pix_color),
    .posX(posX), .posY(posY), .hs(hs), .vs(vs),
    .r(r), .g(g), .b(b), .active(active), .pix_en(pix_en),
    .frame_start(frame_start), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Colour source: red band at posX 2..4, white elsewhere, one clk behind posX.
  always @(posedge clk) begin
    #1;
    pix_color = (posX >= 10'd2 && posX <= 10'd4) ? 12'hF00 : 12'hFFF;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic wait_strobe(output int clks);
    clks = 0;
    do begin
      @(negedge clk);
      clks++;
    end while (!pix_en && clks < 64);
    if (!pix_en) chk("strobe_timeout", 32'(pix_en), 32'd1);
  endtask

  task automatic seek(input int x, input int y);
    int n;
    for (int i = 0; i < 4 * H_TOTAL * V_TOTAL; i++) begin
      wait_strobe(n);
      if (int'(posX) == x && int'(posY) == y) break;
    end
    chk("seek_x", 32'(posX), 32'(x));
    chk("seek_y", 32'(posY), 32'(y));
  endtask

  task automatic wait_fs();
    int i;
    for (i = 0; i < FRAME_CLK + 8; i++) begin
      @(negedge clk);
      if (frame_start) break;
    end
    if (!frame_start) chk("fs_timeout", 32'(frame_start), 32'd1);
  endtask

  // Release at a falling edge: the strobe is consumed by the CLK_DIV-th rising edge.
  task automatic release_and_check(input string tag);
    int n;
    @(negedge clk);
    clrn = 1'b1;
    wait_strobe(n);
    chk({tag, "_first_strobe"}, 32'(n), 32'(CLK_DIV - 1));
    chk({tag, "_posx"}, 32'(posX), 32'd0);
    chk({tag, "_posy"}, 32'(posY), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  task automatic scan(input int nclk);
    logic        prev_en;
    logic [31:0] prev_out, cur_out;
    s_hs_low = 0; s_vs_low = 0; s_act = 0; s_fs = 0; s_strobe = 0; s_hold = 0;
    s_hs_x = -1; s_vs_x = -1; s_vs_y = -1; s_fs_x = -1; s_fs_y = -1; s_fs_cnt = -1;
    prev_en  = pix_en;
    prev_out = {6'd0, posX, hs, vs, active, r, g, b};
    for (int i = 0; i < nclk; i++) begin
      @(negedge clk);
      cur_out = {6'd0, posX, hs, vs, active, r, g, b};
      if (!prev_en && cur_out != prev_out) s_hold++;
      if (!hs) begin
        if (s_hs_low == 0) s_hs_x = int'(posX);
        s_hs_low++;
      end
      if (!vs) begin
        if (s_vs_low == 0) begin
          s_vs_x = int'(posX);
          s_vs_y = int'(posY);
        end
        s_vs_low++;
      end
      if (active) s_act++;
      if (pix_en) s_strobe++;
      if (frame_start) begin
        s_fs++;
        s_fs_x   = int'(posX);
        s_fs_y   = int'(posY);
        s_fs_cnt = int'(frame_cnt);
      end
      prev_en  = pix_en;
      prev_out = cur_out;
    end
  endtask

  initial begin
    int n, strobes, seen;
    for (int p = 0; p < H_TOTAL; p++) exp_rgb[p] = 12'h000;
    exp_rgb[1] = 12'hFFF; exp_rgb[2] = 12'hFFF;
    exp_rgb[3] = 12'hF00; exp_rgb[4] = 12'hF00; exp_rgb[5] = 12'hF00;
    exp_rgb[6] = 12'hFFF; exp_rgb[7] = 12'hFFF; exp_rgb[8] = 12'hFFF;

    repeat (3) @(negedge clk);
    chk("rst_posx", 32'(posX), 32'd0);
    chk("rst_posy", 32'(posY), 32'd0);
    chk("rst_hs", 32'(hs), 32'd1);
    chk("rst_vs", 32'(vs), 32'd1);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_pix_en", 32'(pix_en), 32'd0);
    chk("rst_fs", 32'(frame_start), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);

    release_and_check("rel0");

    // One full line of strobes: period, posX sequence and the posY step at the wrap.
    for (int k = 1; k <= H_TOTAL; k++) begin
      wait_strobe(n);
      chk("pix_period", 32'(n), 32'(CLK_DIV));
      chk("line_posx", 32'(posX), 32'(k % H_TOTAL));
      chk("line_posy", 32'(posY), 32'(k / H_TOTAL));
    end

    scan(LINE_CLK);
    chk("line_strobes", 32'(s_strobe), 32'(H_TOTAL));
    chk("hs_low_clks", 32'(s_hs_low), 32'(H_SYNC * CLK_DIV));
    chk("hs_start_x", 32'(s_hs_x), 32'(H_ACTIVE + H_FP + 1));
    chk("line_active_clks", 32'(s_act), 32'(H_ACTIVE * CLK_DIV));
    chk("line_vs_low", 32'(s_vs_low), 32'd0);
    chk("line_hold", 32'(s_hold), 32'd0);

    scan(FRAME_CLK);
    chk("frame_strobes", 32'(s_strobe), 32'(H_TOTAL * V_TOTAL));
    chk("vs_low_clks", 32'(s_vs_low), 32'(V_SYNC * H_TOTAL * CLK_DIV));
    chk("vs_start_x", 32'(s_vs_x), 32'd1);
    chk("vs_start_y", 32'(s_vs_y), 32'(V_ACTIVE + V_FP));
    chk("frame_hs_clks", 32'(s_hs_low), 32'(V_TOTAL * H_SYNC * CLK_DIV));
    chk("frame_active_clks", 32'(s_act), 32'(V_ACTIVE * H_ACTIVE * CLK_DIV));
    chk("frame_fs_count", 32'(s_fs), 32'd1);
    chk("frame_fs_x", 32'(s_fs_x), 32'd0);
    chk("frame_fs_y", 32'(s_fs_y), 32'd0);
    chk("frame_fs_fcnt", 32'(s_fs_cnt), 32'd1);
    chk("frame_hold", 32'(s_hold), 32'd0);

    // Visible row 2: output shows the colour of posX-1.
    for (int p = 0; p < H_TOTAL; p++) begin
      if (p > 0) wait_strobe(n);
      chk("color_posx", 32'(posX), 32'(p));
      chk("color_rgb", 32'({r, g, b}), 32'(exp_rgb[p]));
      chk("color_active", 32'(active), 32'((p >= 1 && p <= H_ACTIVE) ? 1 : 0));
    end

    // Blanked row: colour input is ignored.
    seek(0, V_ACTIVE + V_FP);
    for (int p = 0; p < H_TOTAL; p++) begin
      if (p > 0) wait_strobe(n);
      chk("blank_rgb", 32'({r, g, b}), 32'd0);
      chk("blank_active", 32'(active), 32'd0);
    end

    // Reset during hsync and vsync: outputs clear before the next rising edge.
    seek(H_ACTIVE + H_FP + 2, V_ACTIVE + V_FP + 1);
    chk("pre_rst_hs", 32'(hs), 32'd0);
    chk("pre_rst_vs", 32'(vs), 32'd0);
    #2 clrn = 1'b0;
    #1;
    chk("async_hs", 32'(hs), 32'd1);
    chk("async_vs", 32'(vs), 32'd1);
    chk("async_posx", 32'(posX), 32'd0);
    chk("async_posy", 32'(posY), 32'd0);
    chk("async_fcnt", 32'(frame_cnt), 32'd0);
    chk("async_pix_en", 32'(pix_en), 32'd0);
    chk("async_rgb0", 32'({r, g, b}), 32'd0);
    release_and_check("rel1");

    // Reset while a red pixel is on the outputs.
    seek(4, 0);
    chk("pre_rst_rgb", 32'({r, g, b}), 32'hF00);
    chk("pre_rst_active", 32'(active), 32'd1);
    #2 clrn = 1'b0;
    #1;
    chk("async_rgb", 32'({r, g, b}), 32'd0);
    chk("async_active", 32'(active), 32'd0);
    chk("async_posx2", 32'(posX), 32'd0);
    release_and_check("rel2");

    // First frame_start only after a whole frame of pixels.
    strobes = 1;
    seen = 0;
    for (int i = 0; i < FRAME_CLK + 8; i++) begin
      @(negedge clk);
      if (frame_start) begin
        seen = 1;
        break;
      end
      if (pix_en) strobes++;
    end
    chk("fs_first_seen", 32'(seen), 32'd1);
    chk("fs_first_pixels", 32'(strobes), 32'(H_TOTAL * V_TOTAL));
    chk("fs_first_fcnt", 32'(frame_cnt), 32'd1);

    for (int k = 2; k <= 256; k++) begin
      wait_fs();
      chk("fcnt_step", 32'(frame_cnt), 32'(k % 256));
    end
    @(negedge clk);
    chk("fs_width", 32'(frame_start), 32'd0);
    chk("fcnt_hold", 32'(frame_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
